ap_ctrl_perf_monitor: RTL and testbench
=======================================

// Module: ap_ctrl_perf_monitor
// PURPOSE
//  Synthesizable N-channel performance monitor for ap_ctrl_hs / ap_ctrl_chain block-level handshakes.
//  Successor to the per-module status monitors: one instance observes up to NUM_CH kernel/pipeline
//  submodules (top, VITIS_LOOP_* pipelines) and accumulates per-channel transaction statistics.
//  Results are read over a registered select/readout port. It sits beside the DUT on-chip and in cosim.
// PARAMETERS
//  NUM_CH      5   number of monitored ap_ctrl channels (1..16)
//  CNT_W       32  width of every statistic counter
//  CHAIN_MODE  0   0: ap_ctrl_hs, ap_continue ignored; 1: ap_ctrl_chain, completion waits on ap_continue
// PORTS
//  clock        in   1               sole clock, rising edge
//  reset        in   1               asynchronous, active-low reset
//  ap_start     in   NUM_CH          per-channel ap_start
//  ap_ready     in   NUM_CH          per-channel ap_ready (counted only)
//  ap_done      in   NUM_CH          per-channel ap_done
//  ap_continue  in   NUM_CH          per-channel ap_continue (used only when CHAIN_MODE=1)
//  clear        in   1               synchronous clear of all statistics and FSMs
//  freeze       in   1               finish indication: stop updating statistics while high
//  rd_ch        in   $clog2(NUM_CH)  channel to read
//  rd_sel       in   3               0 txn_cnt,1 last_lat,2 min_lat,3 max_lat,4 busy_cyc,5 last_ii,6 ready_cnt,7 flags
//  rd_data      out  CNT_W           selected statistic, 1-cycle registered latency
//  busy         out  NUM_CH          channel FSM not in IDLE
//  overrun      out  NUM_CH          sticky: done seen in IDLE, or channel ID out of range
// BEHAVIOUR
//  Reset (reset=0, async): every FSM goes to IDLE; all counters are 0; min_lat = all-ones;
//   rd_data=0, busy=0, overrun=0. clear=1 has the same effect synchronously and takes priority over events.
//  Per-channel FSM: IDLE, BUSY, HOLD (HOLD exists only when CHAIN_MODE=1).
//   IDLE->BUSY on ap_start=1: start event; lat_ctr<=1; last_ii<=ii_ctr; ii_ctr<=1.
//   BUSY: lat_ctr++ each cycle. On ap_done=1, a done event occurs:
//     CHAIN_MODE=0, or ap_continue=1 in the same cycle: completion; go to IDLE.
//     Otherwise: go to HOLD.
//   HOLD: wait for ap_continue=1 (completion; go to IDLE). HOLD cycles are not added to latency.
//   Done and start in the same BUSY cycle with completion: close the old txn, then open a new one.
//     FSM stays in BUSY and lat_ctr<=1.
//   ap_done=1 in IDLE sets overrun[ch] (sticky) and changes no other statistic.
//  On completion: txn_cnt++; last_lat<=lat_ctr, where lat_ctr counts start cycle through done cycle
//   inclusive, so start and done in the same cycle give 1. min_lat/max_lat update by unsigned compare.
//  busy_cyc increments every cycle the FSM is in BUSY or HOLD. ready_cnt increments on every ap_ready=1 cycle.
//  ii_ctr runs from the first start onward. last_ii=0 until the second start.
//  All counters saturate at 2^CNT_W-1 and never wrap. Saturation of any counter sets flags bit1 (sticky).
//  flags word: bit0 overrun, bit1 saturated, bit2 busy, bit3 in HOLD; the remaining bits are 0.
//  freeze=1: counters and FSMs hold their values; readout keeps working.
//   Deasserting freeze resumes counting with no artificial events.
//  rd_data <= stat[rd_ch][rd_sel] on each rising edge.
//   rd_ch >= NUM_CH returns 0 and sets overrun[0].
//  Reset mid-transaction discards the transaction: no partial latency is recorded.
// TESTING
//  T1 hs, ch0: start at cyc 10, done at cyc 19 -> txn_cnt=1, last_lat=10, min=max=10, busy_cyc=10.
//  T2 ch1, three txns with lat 4,7,5 and starts at 0,20,45 -> min=4, max=7, last_lat=5, last_ii=25.
//  T3 back-to-back: done and start in the same cycle on ch2 -> busy stays 1.
//     txn_cnt increments, next last_lat counted from 1.
//  T4 CHAIN_MODE=1: done at cyc 8, ap_continue at cyc 12 -> last_lat excludes cycles 9-12, busy_cyc=lat+4.
//  T5 done pulse with no start on ch3 -> overrun[3]=1; rd_sel=7 shows bit0; txn_cnt stays 0.
//  T6 CNT_W=4, 20 txns; then reset=0 mid-txn -> txn_cnt=15 with flags bit1 set.
//     After reset: all 0, min_lat=4'hF.

Source files
------------

// File: rtl/ap_ctrl_perf_monitor.sv
// Per-channel ap_ctrl_hs / ap_ctrl_chain handshake monitor: transaction count, latency,
// busy cycles, initiation interval and ready counts, read through a registered select port.
module ap_ctrl_perf_monitor #(
  parameter int unsigned  NUM_CH     = 5,
  parameter int unsigned  CNT_W      = 32,
  parameter bit           CHAIN_MODE = 1'b0,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              clear,
  input  logic              freeze,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] overrun
);

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CntMax = '1;
  localparam cnt_t CntOne = cnt_t'(1);

  state_e state_q [NUM_CH];
  state_e state_d [NUM_CH];
  cnt_t   txn_q [NUM_CH], txn_d [NUM_CH];
  cnt_t   last_lat_q [NUM_CH], last_lat_d [NUM_CH];
  cnt_t   min_lat_q [NUM_CH], min_lat_d [NUM_CH];
  cnt_t   max_lat_q [NUM_CH], max_lat_d [NUM_CH];
  cnt_t   busy_cyc_q [NUM_CH], busy_cyc_d [NUM_CH];
  cnt_t   last_ii_q [NUM_CH], last_ii_d [NUM_CH];
  cnt_t   ready_cnt_q [NUM_CH], ready_cnt_d [NUM_CH];
  cnt_t   lat_q [NUM_CH], lat_d [NUM_CH];
  cnt_t   ii_q [NUM_CH], ii_d [NUM_CH];
  logic [NUM_CH-1:0] ovr_q, ovr_d, sat_q, sat_d;
  cnt_t   rd_q, rd_d;

  logic   start_ev, cmpl, hit;
  cnt_t   lat_rec;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  always_comb begin
    state_d     = state_q;
    txn_d       = txn_q;
    last_lat_d  = last_lat_q;
    min_lat_d   = min_lat_q;
    max_lat_d   = max_lat_q;
    busy_cyc_d  = busy_cyc_q;
    last_ii_d   = last_ii_q;
    ready_cnt_d = ready_cnt_q;
    lat_d       = lat_q;
    ii_d        = ii_q;
    ovr_d       = ovr_q;
    sat_d       = sat_q;
    rd_d        = rd_q;
    start_ev    = 1'b0;
    cmpl        = 1'b0;
    hit         = 1'b0;
    lat_rec     = CntOne;

    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      start_ev = 1'b0;
      cmpl     = 1'b0;
      hit      = 1'b0;
      lat_rec  = CntOne;
      if (!freeze) begin
        if (ap_ready[ch]) begin
          hit |= (ready_cnt_q[ch] == CntMax);
          ready_cnt_d[ch] = sat_inc(ready_cnt_q[ch]);
        end
        unique case (state_q[ch])
          StIdle: begin
            if (ap_start[ch]) begin
              start_ev = 1'b1;
              if (!ap_done[ch])                           state_d[ch] = StBusy;
              else if (CHAIN_MODE && !ap_continue[ch])    state_d[ch] = StHold;
              else                                        cmpl = 1'b1;
            end else if (ap_done[ch]) begin
              ovr_d[ch] = 1'b1;
            end
          end
          StBusy: begin
            // lat_q excludes the current cycle; the recorded value includes it
            hit |= (lat_q[ch] == CntMax);
            lat_rec   = sat_inc(lat_q[ch]);
            lat_d[ch] = lat_rec;
            if (ap_done[ch]) begin
              if (CHAIN_MODE && !ap_continue[ch]) begin
                state_d[ch] = StHold;
              end else begin
                cmpl = 1'b1;
                if (ap_start[ch]) start_ev = 1'b1;
                else              state_d[ch] = StIdle;
              end
            end
          end
          StHold: begin
            if (ap_continue[ch]) begin
              lat_rec     = lat_q[ch];
              cmpl        = 1'b1;
              state_d[ch] = StIdle;
            end
          end
          default: state_d[ch] = StIdle;
        endcase

        if (start_ev) begin
          lat_d[ch]     = CntOne;
          last_ii_d[ch] = ii_q[ch];
          ii_d[ch]      = CntOne;
        end else if (ii_q[ch] != '0) begin
          hit |= (ii_q[ch] == CntMax);
          ii_d[ch] = sat_inc(ii_q[ch]);
        end

        if (state_q[ch] != StIdle || start_ev) begin
          hit |= (busy_cyc_q[ch] == CntMax);
          busy_cyc_d[ch] = sat_inc(busy_cyc_q[ch]);
        end

        if (cmpl) begin
          hit |= (txn_q[ch] == CntMax);
          txn_d[ch]      = sat_inc(txn_q[ch]);
          last_lat_d[ch] = lat_rec;
          if (lat_rec < min_lat_q[ch]) min_lat_d[ch] = lat_rec;
          if (lat_rec > max_lat_q[ch]) max_lat_d[ch] = lat_rec;
        end

        if (hit) sat_d[ch] = 1'b1;
      end
    end

    // Readout stays live under freeze
    if (32'(rd_ch) >= NUM_CH) begin
      rd_d     = '0;
      ovr_d[0] = 1'b1;
    end else begin
      unique case (rd_sel)
        3'd0: rd_d = txn_q[rd_ch];
        3'd1: rd_d = last_lat_q[rd_ch];
        3'd2: rd_d = min_lat_q[rd_ch];
        3'd3: rd_d = max_lat_q[rd_ch];
        3'd4: rd_d = busy_cyc_q[rd_ch];
        3'd5: rd_d = last_ii_q[rd_ch];
        3'd6: rd_d = ready_cnt_q[rd_ch];
        3'd7: begin
          rd_d      = '0;
          rd_d[3:0] = {state_q[rd_ch] == StHold, state_q[rd_ch] != StIdle,
                       sat_q[rd_ch], ovr_q[rd_ch]};
        end
      endcase
    end

    if (clear) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        state_d[ch]     = StIdle;
        txn_d[ch]       = '0;
        last_lat_d[ch]  = '0;
        min_lat_d[ch]   = CntMax;
        max_lat_d[ch]   = '0;
        busy_cyc_d[ch]  = '0;
        last_ii_d[ch]   = '0;
        ready_cnt_d[ch] = '0;
        lat_d[ch]       = '0;
        ii_d[ch]        = '0;
      end
      ovr_d = '0;
      sat_d = '0;
      rd_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        state_q[ch]     <= StIdle;
        txn_q[ch]       <= '0;
        last_lat_q[ch]  <= '0;
        min_lat_q[ch]   <= CntMax;
        max_lat_q[ch]   <= '0;
        busy_cyc_q[ch]  <= '0;
        last_ii_q[ch]   <= '0;
        ready_cnt_q[ch] <= '0;
        lat_q[ch]       <= '0;
        ii_q[ch]        <= '0;
      end
      ovr_q <= '0;
      sat_q <= '0;
      rd_q  <= '0;
    end else begin
      state_q     <= state_d;
      txn_q       <= txn_d;
      last_lat_q  <= last_lat_d;
      min_lat_q   <= min_lat_d;
      max_lat_q   <= max_lat_d;
      busy_cyc_q  <= busy_cyc_d;
      last_ii_q   <= last_ii_d;
      ready_cnt_q <= ready_cnt_d;
      lat_q       <= lat_d;
      ii_q        <= ii_d;
      ovr_q       <= ovr_d;
      sat_q       <= sat_d;
      rd_q        <= rd_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) busy[ch] = (state_q[ch] != StIdle);
  end

  assign overrun = ovr_q;
  assign rd_data = rd_q;

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// Bench for ap_ctrl_perf_monitor: hs/32-bit, chain/32-bit and hs/4-bit instances share stimulus
// and are compared every cycle against a cycle-stamp reference model.
module tb_ap_ctrl_perf_monitor;
  localparam int NCH = 5;
  localparam int NU  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] ap_start, ap_ready, ap_done, ap_continue;
  logic       clear, freeze;
  logic [2:0] rd_ch, rd_sel;
  logic [31:0] rd0, rd1;
  logic [3:0]  rd2;
  logic [4:0]  busy0, busy1, busy2, ovr0, ovr1, ovr2;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ap_ctrl_perf_monitor #(.NUM_CH(5), .CNT_W(32), .CHAIN_MODE(1'b0)) dut_hs (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .clear(clear), .freeze(freeze), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd0), .busy(busy0), .overrun(ovr0));

  ap_ctrl_perf_monitor #(.NUM_CH(5), .CNT_W(32), .CHAIN_MODE(1'b1)) dut_chain (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .clear(clear), .freeze(freeze), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd1), .busy(busy1), .overrun(ovr1));

  ap_ctrl_perf_monitor #(.NUM_CH(5), .CNT_W(4), .CHAIN_MODE(1'b0)) dut_narrow (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .clear(clear), .freeze(freeze), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd2), .busy(busy2), .overrun(ovr2));

  // Reference model: phase 0 idle, 1 running, 2 done-but-awaiting-continue
  longint cmax [NU] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  bit     chain_m [NU] = '{1'b0, 1'b1, 1'b0};
  int     phase [NU][NCH];
  longint txn_m [NU][NCH], lastlat_m [NU][NCH], minl_m [NU][NCH], maxl_m [NU][NCH];
  longint busyc_m [NU][NCH], lastii_m [NU][NCH], rdy_m [NU][NCH];
  longint start_at [NU][NCH], held [NU][NCH];
  bit     have_start [NU][NCH], ovr_m [NU][NCH], sat_m [NU][NCH];
  longint exp_rd [NU];
  longint act = 0;

  function automatic longint clip(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < NU; u++) begin
      exp_rd[u] = 0;
      for (int c = 0; c < NCH; c++) begin
        phase[u][c] = 0;      txn_m[u][c] = 0;     lastlat_m[u][c] = 0;
        minl_m[u][c] = cmax[u]; maxl_m[u][c] = 0;  busyc_m[u][c] = 0;
        lastii_m[u][c] = 0;   rdy_m[u][c] = 0;     start_at[u][c] = 0;
        held[u][c] = 0;       have_start[u][c] = 0;
        ovr_m[u][c] = 0;      sat_m[u][c] = 0;
      end
    end
  endtask

  function automatic longint stat(input int u, input int c, input int sel);
    case (sel)
      0: return clip(txn_m[u][c], cmax[u]);
      1: return lastlat_m[u][c];
      2: return minl_m[u][c];
      3: return maxl_m[u][c];
      4: return clip(busyc_m[u][c], cmax[u]);
      5: return lastii_m[u][c];
      6: return clip(rdy_m[u][c], cmax[u]);
      default: return longint'(ovr_m[u][c]) | (longint'(sat_m[u][c]) << 1) |
                      (longint'(phase[u][c] != 0) << 2) | (longint'(phase[u][c] == 2) << 3);
    endcase
  endfunction

  task automatic model_step();
    bit st, dn, ct, was_busy, sev, cmp;
    longint L, m, lc;
    if (clear) begin
      model_reset();
    end else begin
      for (int u = 0; u < NU; u++) begin
        if (int'(rd_ch) >= NCH) begin
          exp_rd[u] = 0;
          ovr_m[u][0] = 1'b1;
        end else begin
          exp_rd[u] = stat(u, int'(rd_ch), int'(rd_sel));
        end
      end
      if (!freeze) begin
        for (int u = 0; u < NU; u++) begin
          m = cmax[u];
          for (int c = 0; c < NCH; c++) begin
            st = ap_start[c]; dn = ap_done[c]; ct = ap_continue[c];
            if (ap_ready[c]) begin
              rdy_m[u][c]++;
              if (rdy_m[u][c] > m) sat_m[u][c] = 1'b1;
            end
            was_busy = (phase[u][c] != 0);
            sev = 1'b0; cmp = 1'b0; L = 1;
            case (phase[u][c])
              0: begin
                if (st) begin
                  sev = 1'b1;
                  if (!dn) phase[u][c] = 1;
                  else if (chain_m[u] && !ct) begin phase[u][c] = 2; held[u][c] = 1; end
                  else cmp = 1'b1;
                end else if (dn) ovr_m[u][c] = 1'b1;
              end
              1: begin
                L = act - start_at[u][c] + 1;
                if (L > m) sat_m[u][c] = 1'b1;
                if (dn) begin
                  if (chain_m[u] && !ct) begin phase[u][c] = 2; held[u][c] = L; end
                  else begin
                    cmp = 1'b1;
                    if (st) sev = 1'b1;
                    else    phase[u][c] = 0;
                  end
                end
              end
              default: begin
                if (ct) begin L = held[u][c]; cmp = 1'b1; phase[u][c] = 0; end
              end
            endcase
            if (was_busy || sev) begin
              busyc_m[u][c]++;
              if (busyc_m[u][c] > m) sat_m[u][c] = 1'b1;
            end
            if (sev) begin
              lastii_m[u][c] = have_start[u][c] ? clip(act - start_at[u][c], m) : 0;
              have_start[u][c] = 1'b1;
              start_at[u][c] = act;
            end else if (have_start[u][c] && (act - start_at[u][c] + 1 > m)) begin
              sat_m[u][c] = 1'b1;
            end
            if (cmp) begin
              txn_m[u][c]++;
              if (txn_m[u][c] > m) sat_m[u][c] = 1'b1;
              lc = clip(L, m);
              lastlat_m[u][c] = lc;
              if (lc < minl_m[u][c]) minl_m[u][c] = lc;
              if (lc > maxl_m[u][c]) maxl_m[u][c] = lc;
            end
          end
        end
        act++;
      end
    end
  endtask

  function automatic logic [4:0] exp_busy(input int u);
    logic [4:0] b;
    for (int c = 0; c < NCH; c++) b[c] = (phase[u][c] != 0);
    return b;
  endfunction

  function automatic logic [4:0] exp_ovr(input int u);
    logic [4:0] o;
    for (int c = 0; c < NCH; c++) o[c] = ovr_m[u][c];
    return o;
  endfunction

  function automatic logic [63:0] obs_rd(input int u);
    case (u)
      0: return {32'b0, rd0};
      1: return {32'b0, rd1};
      default: return {60'b0, rd2};
    endcase
  endfunction

  function automatic logic [4:0] obs_busy(input int u);
    case (u)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic [4:0] obs_ovr(input int u);
    case (u)
      0: return ovr0;
      1: return ovr1;
      default: return ovr2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("u%0d_rd_data", u), obs_rd(u), exp_rd[u]);
      chk($sformatf("u%0d_busy", u), {59'b0, obs_busy(u)}, {59'b0, exp_busy(u)});
      chk($sformatf("u%0d_overrun", u), {59'b0, obs_ovr(u)}, {59'b0, exp_ovr(u)});
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic pulse(input logic [4:0] st, input logic [4:0] dn);
    ap_start = st;
    ap_done  = dn;
    cyc();
    ap_start = '0;
    ap_done  = '0;
  endtask

  task automatic read_const(input int u, input logic [2:0] ch, input logic [2:0] sel,
                            input logic [63:0] exp, input string tag);
    rd_ch  = ch;
    rd_sel = sel;
    cyc();
    chk(tag, obs_rd(u), exp);
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    clear = 1'b0; freeze = 1'b0; rd_ch = '0; rd_sel = '0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;
    read_const(0, 3'd0, 3'd2, 64'hFFFF_FFFF, "reset_min_lat");
    read_const(2, 3'd0, 3'd2, 64'hF, "reset_min_lat_narrow");

    // T1: single transaction, latency 10
    pulse(5'b00001, 5'b0);
    idle(8);
    pulse(5'b0, 5'b00001);
    read_const(0, 3'd0, 3'd0, 64'd1,  "t1_txn_cnt");
    read_const(0, 3'd0, 3'd1, 64'd10, "t1_last_lat");
    read_const(0, 3'd0, 3'd2, 64'd10, "t1_min_lat");
    read_const(0, 3'd0, 3'd3, 64'd10, "t1_max_lat");
    read_const(0, 3'd0, 3'd4, 64'd10, "t1_busy_cyc");

    // T2: ch1 latencies 4,7,5 with starts at 0,20,45
    for (int k = 0; k < 50; k++) begin
      ap_start = (k == 0 || k == 20 || k == 45) ? 5'b00010 : 5'b0;
      ap_done  = (k == 3 || k == 26 || k == 49) ? 5'b00010 : 5'b0;
      cyc();
    end
    ap_start = '0; ap_done = '0;
    read_const(0, 3'd1, 3'd2, 64'd4,  "t2_min_lat");
    read_const(0, 3'd1, 3'd3, 64'd7,  "t2_max_lat");
    read_const(0, 3'd1, 3'd1, 64'd5,  "t2_last_lat");
    read_const(0, 3'd1, 3'd5, 64'd25, "t2_last_ii");
    read_const(0, 3'd1, 3'd0, 64'd3,  "t2_txn_cnt");

    // T3: back-to-back done+start on ch2
    pulse(5'b00100, 5'b0);
    idle(3);
    pulse(5'b00100, 5'b00100);
    chk("t3_b2b_busy", {63'b0, busy0[2]}, 64'd1);
    idle(2);
    pulse(5'b0, 5'b00100);
    read_const(0, 3'd2, 3'd0, 64'd2, "t3_txn_cnt");
    read_const(0, 3'd2, 3'd1, 64'd4, "t3_last_lat");
    read_const(0, 3'd2, 3'd3, 64'd5, "t3_max_lat");

    // T4: chain mode, done at 8, continue at 12 on ch4
    ap_continue = '0;
    pulse(5'b10000, 5'b0);
    idle(7);
    pulse(5'b0, 5'b10000);
    read_const(1, 3'd4, 3'd7, 64'hC, "t4_hold_flags");
    idle(2);
    ap_continue = 5'b10000;
    cyc();
    ap_continue = '1;
    read_const(1, 3'd4, 3'd1, 64'd9,  "t4_last_lat");
    read_const(1, 3'd4, 3'd4, 64'd13, "t4_busy_cyc");
    read_const(0, 3'd4, 3'd4, 64'd9,  "t4_hs_busy_cyc");

    // T5: done without start, and out-of-range readout
    pulse(5'b0, 5'b01000);
    chk("t5_overrun3", {63'b0, ovr0[3]}, 64'd1);
    read_const(0, 3'd3, 3'd7, 64'h1, "t5_flags");
    read_const(0, 3'd3, 3'd0, 64'd0, "t5_txn_cnt");
    read_const(0, 3'd6, 3'd0, 64'd0, "rd_ch_range_data");
    chk("rd_ch_range_ovr0", {63'b0, ovr0[0]}, 64'd1);
    rd_ch = '0;

    // Freeze mid-transaction: frozen cycles are not counted
    pulse(5'b00001, 5'b0);
    idle(2);
    freeze = 1'b1;
    idle(5);
    freeze = 1'b0;
    idle(1);
    pulse(5'b0, 5'b00001);
    read_const(0, 3'd0, 3'd1, 64'd5, "freeze_last_lat");
    read_const(0, 3'd0, 3'd0, 64'd2, "freeze_txn_cnt");

    // T6: narrow counters saturate, then reset mid-transaction
    repeat (20) begin
      pulse(5'b00001, 5'b0);
      pulse(5'b0, 5'b00001);
    end
    pulse(5'b00001, 5'b0);
    read_const(2, 3'd0, 3'd0, 64'd15, "t6_txn_sat");
    rd_sel = 3'd7;
    cyc();
    chk("t6_flag_sat", {63'b0, rd2[1]}, 64'd1);
    do_reset();
    read_const(2, 3'd0, 3'd0, 64'd0, "t6_post_txn");
    read_const(2, 3'd0, 3'd2, 64'hF, "t6_post_min");
    read_const(2, 3'd0, 3'd7, 64'd0, "t6_post_flags");
    read_const(0, 3'd0, 3'd1, 64'd0, "t6_post_last_lat");

    // Randomized traffic with occasional freeze, clear and reset
    for (int i = 0; i < 3000; i++) begin
      ap_start    = 5'($urandom & $urandom);
      ap_done     = 5'($urandom & $urandom);
      ap_continue = 5'($urandom);
      ap_ready    = 5'($urandom);
      freeze      = ($urandom_range(0, 15) == 0);
      clear       = ($urandom_range(0, 199) == 0);
      rd_ch       = 3'($urandom_range(0, 5));
      rd_sel      = 3'($urandom);
      cyc();
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    ap_start = '0; ap_done = '0; ap_ready = '0; ap_continue = '1;
    freeze = 1'b0; clear = 1'b1;
    cyc();
    clear = 1'b0;
    read_const(1, 3'd2, 3'd2, 64'hFFFF_FFFF, "clear_min_lat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
